// File: rtl/mips_pkg.sv
// MIPS instruction field positions and the fetch-entry type shared by IF, the
// IF/ID queue and the ID stage.
package mips_pkg;

   localparam int INSTR_W    = 32;

   localparam int OPCODE_MSB = 31;
   localparam int OPCODE_LSB = 26;
   localparam int RS_MSB     = 25;
   localparam int RS_LSB     = 21;
   localparam int RT_MSB     = 20;
   localparam int RT_LSB     = 16;
   localparam int RD_MSB     = 15;
   localparam int RD_LSB     = 11;
   localparam int SHAMT_MSB  = 10;
   localparam int SHAMT_LSB  = 6;
   localparam int FUNCT_MSB  = 5;
   localparam int FUNCT_LSB  = 0;
   localparam int IMM_MSB    = 15;
   localparam int IMM_LSB    = 0;

   // sll $0,$0,0 is the all-zero word, used as the bubble.
   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc_plus_4;
      logic [31:0] instruction;
   } fetch_entry_t;

endpackage

// File: rtl/if_id_fetch_queue_if.sv
// IF -> queue -> ID signal bundle; the queue takes the slave view, the
// surrounding pipeline (or a bench) takes the master view.
interface if_id_fetch_queue_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int DEPTH  = 4
);
   localparam int PTR_W = $clog2(DEPTH);

   logic              i_push_valid;
   logic              o_push_ready;
   logic [ADDR_W-1:0] i_pc_plus_4;
   logic [DATA_W-1:0] i_instruction;
   logic              i_pop;
   logic              i_stall;
   logic              i_flush;
   logic              o_valid;
   logic [ADDR_W-1:0] o_pc_plus_4;
   logic [DATA_W-1:0] o_instruction;
   logic [5:0]        o_opcode;
   logic [4:0]        o_rs;
   logic [4:0]        o_rt;
   logic [4:0]        o_rd;
   logic [4:0]        o_shamt;
   logic [5:0]        o_funct;
   logic [15:0]       o_imm;
   logic [PTR_W:0]    o_count;
   logic              o_full;
   logic              o_empty;
   logic              o_overflow;

   modport slave (
      input  i_push_valid, i_pc_plus_4, i_instruction, i_pop, i_stall, i_flush,
      output o_push_ready, o_valid, o_pc_plus_4, o_instruction,
             o_opcode, o_rs, o_rt, o_rd, o_shamt, o_funct, o_imm,
             o_count, o_full, o_empty, o_overflow
   );

   modport master (
      output i_push_valid, i_pc_plus_4, i_instruction, i_pop, i_stall, i_flush,
      input  o_push_ready, o_valid, o_pc_plus_4, o_instruction,
             o_opcode, o_rs, o_rt, o_rd, o_shamt, o_funct, o_imm,
             o_count, o_full, o_empty, o_overflow
   );

endinterface

// File: rtl/instr_field_split.sv
// Purely combinational MIPS field slicer; shared with the ID stage so both
// agree on field positions.
module instr_field_split
   import mips_pkg::*;
(
   input  logic [INSTR_W-1:0]                instr_i,
   output logic [OPCODE_MSB-OPCODE_LSB:0]    opcode_o,
   output logic [RS_MSB-RS_LSB:0]            rs_o,
   output logic [RT_MSB-RT_LSB:0]            rt_o,
   output logic [RD_MSB-RD_LSB:0]            rd_o,
   output logic [SHAMT_MSB-SHAMT_LSB:0]      shamt_o,
   output logic [FUNCT_MSB-FUNCT_LSB:0]      funct_o,
   output logic [IMM_MSB-IMM_LSB:0]          imm_o
);

   assign opcode_o = instr_i[OPCODE_MSB:OPCODE_LSB];
   assign rs_o     = instr_i[RS_MSB:RS_LSB];
   assign rt_o     = instr_i[RT_MSB:RT_LSB];
   assign rd_o     = instr_i[RD_MSB:RD_LSB];
   assign shamt_o  = instr_i[SHAMT_MSB:SHAMT_LSB];
   assign funct_o  = instr_i[FUNCT_MSB:FUNCT_LSB];
   assign imm_o    = instr_i[IMM_MSB:IMM_LSB];

endmodule

// File: rtl/if_id_fetch_queue.sv
// DEPTH-entry in-order queue of {pc_plus_4, instruction} between IF and ID,
// presenting the head pre-split into MIPS fields and a NOP bubble when empty.
module if_id_fetch_queue
   import mips_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int DEPTH  = 4
) (
   input logic                 i_clk,
   input logic                 i_reset,
   if_id_fetch_queue_if.slave  bus
);

   localparam int PTR_W = $clog2(DEPTH);

   generate
      if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
         $error("if_id_fetch_queue: DEPTH must be a power of two and >= 2");
      end
      if (DATA_W != INSTR_W) begin : g_bad_data_w
         $error("if_id_fetch_queue: DATA_W must be 32 for MIPS field slicing");
      end
   endgenerate

   typedef struct packed {
      logic [ADDR_W-1:0] pc_plus_4;
      logic [DATA_W-1:0] instruction;
   } entry_t;

   entry_t           mem_q [DEPTH];
   logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
   logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             overflow_q, overflow_d;

   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   entry_t           headEntry;
   logic [DATA_W-1:0] headInstr;

   assign full  = (count_q == (PTR_W+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign push  = bus.i_push_valid & ~full;
   assign pop   = bus.i_pop & ~bus.i_stall & ~empty;

   // Flush wins over push/pop: anything arriving alongside it is wrong-path.
   always_comb begin
      wrPtr_d    = wrPtr_q;
      rdPtr_d    = rdPtr_q;
      count_d    = count_q;
      overflow_d = overflow_q | (bus.i_push_valid & full);
      if (bus.i_flush) begin
         wrPtr_d = '0;
         rdPtr_d = '0;
         count_d = '0;
      end else begin
         if (push) wrPtr_d = wrPtr_q + PTR_W'(1);
         if (pop)  rdPtr_d = rdPtr_q + PTR_W'(1);
         count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wrPtr_q    <= wrPtr_d;
         rdPtr_q    <= rdPtr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage is deliberately unreset; the empty mask hides stale contents.
   always_ff @(posedge i_clk) begin
      if (push && !bus.i_flush) begin
         mem_q[wrPtr_q] <= '{pc_plus_4: bus.i_pc_plus_4, instruction: bus.i_instruction};
      end
   end

   assign headEntry = mem_q[rdPtr_q];
   assign headInstr = empty ? NOP_INSTR : headEntry.instruction;

   assign bus.o_push_ready  = ~full;
   assign bus.o_valid       = ~empty;
   assign bus.o_pc_plus_4   = empty ? '0 : headEntry.pc_plus_4;
   assign bus.o_instruction = headInstr;
   assign bus.o_count       = count_q;
   assign bus.o_full        = full;
   assign bus.o_empty       = empty;
   assign bus.o_overflow    = overflow_q;

   instr_field_split u_split (
      .instr_i  (headInstr),
      .opcode_o (bus.o_opcode),
      .rs_o     (bus.o_rs),
      .rt_o     (bus.o_rt),
      .rd_o     (bus.o_rd),
      .shamt_o  (bus.o_shamt),
      .funct_o  (bus.o_funct),
      .imm_o    (bus.o_imm)
   );

endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Directed and randomized checks of the IF/ID fetch queue against a
// queue-based reference model.
module tb_if_id_fetch_queue;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 32;
   localparam int DEPTH  = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   int checks = 0;
   int errors = 0;

   logic [63:0] model [$];
   logic        modelOvf = 1'b0;

   if_id_fetch_queue_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

   if_id_fetch_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .i_clk   (clk),
      .i_reset (rst_n),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected outputs come from the model: head of the queue, or all zero when empty.
   task automatic checkOutput(input string tag);
      logic [63:0] head;
      logic [31:0] ins;
      logic [31:0] pc;
      int n;
      n    = model.size();
      head = (n == 0) ? 64'h0 : model[0];
      ins  = head[31:0];
      pc   = head[63:32];
      chk({tag, ".valid"},   bus.o_valid,        64'(n != 0));
      chk({tag, ".pc"},      bus.o_pc_plus_4,    64'(pc));
      chk({tag, ".instr"},   bus.o_instruction,  64'(ins));
      chk({tag, ".opcode"},  bus.o_opcode,       64'(ins[31:26]));
      chk({tag, ".rs"},      bus.o_rs,           64'(ins[25:21]));
      chk({tag, ".rt"},      bus.o_rt,           64'(ins[20:16]));
      chk({tag, ".rd"},      bus.o_rd,           64'(ins[15:11]));
      chk({tag, ".shamt"},   bus.o_shamt,        64'(ins[10:6]));
      chk({tag, ".funct"},   bus.o_funct,        64'(ins[5:0]));
      chk({tag, ".imm"},     bus.o_imm,          64'(ins[15:0]));
      chk({tag, ".count"},   bus.o_count,        64'(n));
      chk({tag, ".full"},    bus.o_full,         64'(n == DEPTH));
      chk({tag, ".empty"},   bus.o_empty,        64'(n == 0));
      chk({tag, ".ready"},   bus.o_push_ready,   64'(n < DEPTH));
      chk({tag, ".ovf"},     bus.o_overflow,     64'(modelOvf));
   endtask

   // Drive one cycle of inputs, advance the model, clock, then check.
   task automatic applyStimulus(input logic pv, input logic [31:0] pc, input logic [31:0] ins,
                                input logic pp, input logic st, input logic fl,
                                input string tag);
      bit isFull;
      bit isEmpty;
      bus.i_push_valid  = pv;
      bus.i_pc_plus_4   = pc;
      bus.i_instruction = ins;
      bus.i_pop         = pp;
      bus.i_stall       = st;
      bus.i_flush       = fl;
      isFull  = (model.size() == DEPTH);
      isEmpty = (model.size() == 0);
      if (pv && isFull) modelOvf = 1'b1;
      if (fl) begin
         model.delete();
      end else begin
         if (pp && !st && !isEmpty) void'(model.pop_front());
         if (pv && !isFull) model.push_back({pc, ins});
      end
      @(posedge clk);
      #1;
      bus.i_push_valid = 1'b0;
      bus.i_pop        = 1'b0;
      bus.i_stall      = 1'b0;
      bus.i_flush      = 1'b0;
      checkOutput(tag);
   endtask

   initial begin
      logic [31:0] words [4];
      logic [31:0] r;
      logic [31:0] p;
      bus.i_push_valid  = 1'b0;
      bus.i_pc_plus_4   = '0;
      bus.i_instruction = '0;
      bus.i_pop         = 1'b0;
      bus.i_stall       = 1'b0;
      bus.i_flush       = 1'b0;

      // Reset state is visible before any clock edge.
      #3;
      checkOutput("reset");
      #5;
      rst_n = 1'b1;

      // Single entry, field decode, then pop back to a bubble.
      applyStimulus(1, 32'h4, 32'h014B_4820, 0, 0, 0, "push1");
      chk("add.opcode", bus.o_opcode, 64'd0);
      chk("add.rs",     bus.o_rs,     64'd10);
      chk("add.rt",     bus.o_rt,     64'd11);
      chk("add.rd",     bus.o_rd,     64'd9);
      chk("add.shamt",  bus.o_shamt,  64'd0);
      chk("add.funct",  bus.o_funct,  64'h20);
      chk("add.count",  bus.o_count,  64'd1);
      applyStimulus(0, 0, 0, 1, 0, 0, "pop1");
      chk("bubble.instr", bus.o_instruction, 64'd0);

      // Fill, overflow, drain in order.
      for (int i = 0; i < 4; i++) begin
         words[i] = $urandom() | 32'h1;
         applyStimulus(1, 32'h100 + 32'(4 * i), words[i], 0, 0, 0, "fill");
      end
      chk("fill.full",  bus.o_full,       64'd1);
      chk("fill.ready", bus.o_push_ready, 64'd0);
      applyStimulus(1, 32'hDEAD, 32'hFFFF_FFFF, 0, 0, 0, "overflow");
      chk("overflow.flag", bus.o_overflow, 64'd1);
      for (int i = 0; i < 4; i++) begin
         chk("drain.order", bus.o_instruction, 64'(words[i]));
         applyStimulus(0, 0, 0, 1, 0, 0, "drain");
      end
      chk("drain.empty", bus.o_empty, 64'd1);

      // Streaming push+pop across pointer wrap.
      applyStimulus(1, 32'h200, $urandom(), 0, 0, 0, "prefill");
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1, 32'h204 + 32'(4 * i), $urandom(), 1, 0, 0, "stream");
         chk("stream.count", bus.o_count, 64'd1);
      end

      // Flush with concurrent push and pop on three entries.
      applyStimulus(1, 32'h300, $urandom(), 0, 0, 0, "pre3a");
      applyStimulus(1, 32'h304, $urandom(), 0, 0, 0, "pre3b");
      applyStimulus(1, 32'h308, 32'h2002_0005, 1, 0, 1, "flush");
      chk("flush.count", bus.o_count,    64'd0);
      chk("flush.ovf",   bus.o_overflow, 64'd1);
      applyStimulus(1, 32'h400, 32'h8C43_0010, 0, 0, 0, "postflush");

      // Stall masks pop; pop on empty is ignored.
      applyStimulus(1, 32'h404, $urandom(), 0, 0, 0, "two");
      applyStimulus(0, 0, 0, 1, 1, 0, "stallpop");
      chk("stall.count", bus.o_count, 64'd2);
      applyStimulus(0, 0, 0, 1, 0, 0, "popA");
      applyStimulus(0, 0, 0, 1, 0, 0, "popB");
      applyStimulus(0, 0, 0, 1, 0, 0, "popEmpty");
      applyStimulus(1, 32'h500, 32'h1234_5678, 1, 0, 0, "pushPopEmpty");

      // Asynchronous reset between edges.
      applyStimulus(1, 32'h504, $urandom(), 0, 0, 0, "preRst");
      #2;
      rst_n = 1'b0;
      model.delete();
      modelOvf = 1'b0;
      #1;
      checkOutput("midReset");
      chk("midReset.count", bus.o_count, 64'd0);
      #2;
      rst_n = 1'b1;
      applyStimulus(1, 32'h600, 32'h0800_0040, 0, 0, 0, "afterRst");

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         r = $urandom();
         p = $urandom() & 32'hFFFF_FFFC;
         applyStimulus(r[7:0] < 8'd160, p, $urandom(), r[15:8] < 8'd128,
                       r[23:16] < 8'd64, r[31:24] < 8'd10, "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/if_id_fetch_queue.md
Name: if_id_fetch_queue

Overview:
Parametrised successor to the single-entry IF/ID register: a DEPTH-entry instruction queue between IF and ID.
- Holds {pc_plus_4, instruction} pairs in order and decouples fetch from decode stalls.
- Presents the head entry pre-split into MIPS fields, in the same field set the ID stage consumes today.
- Supports branch/jump flush, ID stall, and bubble (NOP) output when empty.

Parameters:
DATA_W, 32, instruction width (fixed field slicing assumes 32)
ADDR_W, 32, pc_plus_4 width
DEPTH, 4, queue entries; power of two, >=2; elaboration error otherwise
PTR_W, $clog2(DEPTH), local, pointer width

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  asynchronous, active-low reset
i_push_valid  in  1  IF presents an entry
o_push_ready  out  1  = !full (no same-cycle pass-through when full)
i_pc_plus_4  in  ADDR_W  IF PC+4
i_instruction  in  DATA_W  IF instruction word
i_pop  in  1  ID consumes head
i_stall  in  1  ID hazard stall; masks i_pop
i_flush  in  1  taken branch/jump; discard all entries
o_valid  out  1  head entry valid
o_pc_plus_4  out  ADDR_W  head PC+4 (0 when empty)
o_instruction  out  DATA_W  head instruction (0 = NOP when empty)
o_opcode  out  6  [31:26]
o_rs  out  5  [25:21]
o_rt  out  5  [20:16]
o_rd  out  5  [15:11]
o_shamt  out  5  [10:6]
o_funct  out  6  [5:0]
o_imm  out  16  [15:0]
o_count  out  PTR_W+1  occupancy 0..DEPTH
o_full  out  1  count==DEPTH
o_empty  out  1  count==0
o_overflow  out  1  sticky: push attempted while full

Behaviour:
- Reset (i_reset=0, async, no clock needed): wr_ptr=rd_ptr=0, count=0, o_overflow=0; every data/field output 0, o_valid=0, o_empty=1, o_full=0, o_push_ready=1. Storage array is not reset.
- Effective signals:
  - push = i_push_valid & !full
  - pop = i_pop & !i_stall & !empty
- Latency: an entry pushed at edge N is at head (o_valid=1) after edge N if queue was empty. No combinational input->output path.
- Head outputs: read combinationally from mem[rd_ptr]. All field outputs are sliced from the masked instruction, so an empty queue yields all-zero fields (NOP bubble).
- Per edge, priority order:
  1. i_flush: wr_ptr=rd_ptr=0, count=0. Concurrent push and pop are discarded (wrong path).
  2. Otherwise push writes mem[wr_ptr], wr_ptr+1. Pop advances rd_ptr+1.
  3. count += push - pop.
- Pointers wrap DEPTH-1 -> 0 naturally via PTR_W truncation.
- Push and pop in the same cycle, non-empty: count unchanged, order preserved.
- Push and pop in the same cycle when empty: the pop is ignored; count becomes 1.
- Push while full: entry dropped; o_overflow set until reset. Flush does not clear o_overflow.
- Pop while empty, or i_pop while i_stall: no state change.
- Reset asserted mid-operation: state cleared immediately.
- After reset deasserts, first edge behaves as from empty.

Decomposition:
- Package mips_pkg:
  - field bit positions (OPCODE_MSB/LSB, RS_*, RT_*, RD_*, SHAMT_*, FUNCT_*, IMM_*)
  - NOP_INSTR = 32'h0000_0000
  - typedef for the fetch entry {pc_plus_4, instruction}
- One natural sub-module: instr_field_split (combinational field slicer from the package constants), reused later by ID.

Test Plan:
1. Reset, then push 0x014B4820 with pc_plus_4=0x4 -> after next edge: o_valid=1, opcode=0, rs=10, rt=11, rd=9, shamt=0, funct=0x20, count=1; pop -> o_valid=0, o_instruction=0.
2. DEPTH=4: push 4 distinct words with no pop -> o_full=1, o_push_ready=0. Then:
   - 5th push: dropped, o_overflow=1.
   - Four pops: return words in push order; then o_empty=1.
3. Continuous push+pop for 10 cycles after one prefill -> count stays 1, outputs follow input with one-entry lag across pointer wrap.
4. Queue holding 3 entries, i_flush=1 with concurrent push and pop:
   - Next edge: count=0, o_valid=0, all fields 0, o_overflow unchanged.
   - Next push appears normally.
5. i_pop=1 with i_stall=1 on 2 entries -> head and count unchanged. Pop when empty -> count stays 0, no underflow.
6. Two entries queued, i_reset driven low between clock edges -> outputs zero and count=0 before the next edge. Release reset, push -> normal operation.
